dat_mem_sync: RTL and testbench

DAT_MEM_SYNC -- requirements
Module: dat_mem_sync

---
 rtl/dat_mem_sync.sv | 99 +++++++++
 tb/tb_dat_mem_sync.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_sync.sv
// Single-port-read / single-port-write synchronous data memory that zeroes itself by walking the array after reset or on request.
// Optional define DAT_MEM_SYNC_FWD_EN selects write-first forwarding for same-address read/write; default is read-first.
module dat_mem_sync #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic          clr_req,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] mem [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_word;

    assign busy = (state == CLEAR);

    // The clear walk and normal writes share the single write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = dat_in;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

`ifdef DAT_MEM_SYNC_FWD_EN
    assign rd_word = (wr_en && (wr_addr == rd_addr)) ? dat_in : mem[rd_addr];
`else
    assign rd_word = mem[rd_addr];
`endif

    // Storage has no reset so it maps onto block RAM; the clear walk zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    rd_valid <= 1'b0;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state   <= READY;
                        clr_cnt <= '0;
                    end
                end
                READY: begin
                    rd_valid <= rd_en;
                    if (rd_en) begin
                        rd_data <= rd_word;
                    end
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dat_mem_sync.sv
// Testbench for dat_mem_sync: directed scenarios with literal expectations plus randomized traffic checked every cycle
// against an array-based reference model. Honours DAT_MEM_SYNC_FWD_EN the same way the design does.
module tb_dat_mem_sync;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
`ifdef DAT_MEM_SYNC_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] dat_in;
    logic          clr_req;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    dat_mem_sync #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .dat_in   (dat_in),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a clear wipes the whole array at once and then just counts down DEPTH busy cycles.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_busy;

    assign exp_busy = (m_left != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left    <= DEPTH;
            exp_valid <= 1'b0;
            exp_data  <= '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        end else if (m_left > 0) begin
            m_left    <= m_left - 1;
            exp_valid <= 1'b0;
        end else begin
            exp_valid <= rd_en;
            if (rd_en) exp_data <= (FWD && wr_en && (wr_addr == rd_addr)) ? dat_in : m_mem[rd_addr];
            if (wr_en) m_mem[wr_addr] <= dat_in;
            if (clr_req) begin
                m_left <= DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model busy", 32'(busy), 32'(exp_busy));
            checkOutput("model rd_valid", 32'(rd_valid), 32'(exp_valid));
            checkOutput("model rd_data", 32'(rd_data), 32'(exp_data));
        end
    end

    task automatic applyStimulus(input logic re, input logic [AW-1:0] ra, input logic we,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic cr);
        @(negedge clk);
        rd_en   = re;
        rd_addr = ra;
        wr_en   = we;
        wr_addr = wa;
        dat_in  = wd;
        clr_req = cr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        dat_in  = '0;
        clr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("reset rd_data", 32'(rd_data), 32'h0);
        checkOutput("reset rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h1);

        // Initial clear length after reset release.
        #2 rst_n = 1'b1;
        wait_ready(n);
        checkOutput("initial clear cycles", 32'(n), 32'd256);

        applyStimulus(1'b1, 8'h00, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, '0, '0, 1'b0);
        checkOutput("read 0x00 data", 32'(rd_data), 32'h00);
        checkOutput("read 0x00 valid", 32'(rd_valid), 32'h1);
        idle();
        checkOutput("read 0xFF data", 32'(rd_data), 32'h00);
        idle();
        checkOutput("idle valid low", 32'(rd_valid), 32'h0);

        // Write then read back one cycle later.
        applyStimulus(1'b0, '0, 1'b1, 8'h10, 8'hA5, 1'b0);
        applyStimulus(1'b1, 8'h10, 1'b0, '0, '0, 1'b0);
        idle();
        checkOutput("readback 0x10 data", 32'(rd_data), 32'hA5);
        checkOutput("readback 0x10 valid", 32'(rd_valid), 32'h1);
        idle();
        checkOutput("valid single pulse", 32'(rd_valid), 32'h0);
        checkOutput("rd_data holds", 32'(rd_data), 32'hA5);

        // Same-address read and write.
        applyStimulus(1'b0, '0, 1'b1, 8'h20, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h20, 1'b1, 8'h20, 8'h3C, 1'b0);
        idle();
        checkOutput("collision data", 32'(rd_data), FWD ? 32'h3C : 32'h11);
        applyStimulus(1'b1, 8'h20, 1'b0, '0, '0, 1'b0);
        idle();
        checkOutput("post-collision data", 32'(rd_data), 32'h3C);

        // Back-to-back reads at full throughput.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 8'(i), 8'(i), 1'b0);
        for (int i = 0; i <= 8; i++) begin
            applyStimulus(i < 8, 8'(i), 1'b0, '0, '0, 1'b0);
            if (i > 0) begin
                checkOutput("burst valid", 32'(rd_valid), 32'h1);
                checkOutput("burst data", 32'(rd_data), 32'(i - 1));
            end
        end

        // Clear request with a same-cycle read; traffic during the clear must be ignored.
        applyStimulus(1'b0, '0, 1'b1, 8'h05, 8'h77, 1'b0);
        applyStimulus(1'b1, 8'h05, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 8'h05, 1'b1, 8'h05, 8'hEE, 1'b0);
        checkOutput("read with clr_req", 32'(rd_data), 32'h77);
        checkOutput("busy after clr_req", 32'(busy), 32'h1);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b1, 8'h05, 8'hEE, 1'($urandom_range(0, 1)));
            checkOutput("clear ignores read", 32'(rd_valid), 32'h0);
            checkOutput("clear holds rd_data", 32'(rd_data), 32'h77);
        end
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        clr_req = 1'b0;
        checkOutput("requested clear cycles", 32'(n), 32'd256);
        applyStimulus(1'b1, 8'h05, 1'b0, '0, '0, 1'b0);
        idle();
        checkOutput("0x05 after clear", 32'(rd_data), 32'h00);

        // Reset in the middle of a clear restarts it from the beginning.
        applyStimulus(1'b0, '0, 1'b1, 8'h10, 8'hA5, 1'b0);
        applyStimulus(1'b1, 8'h10, 1'b0, '0, '0, 1'b1);
        repeat (100) idle();
        checkOutput("data before reset", 32'(rd_data), 32'hA5);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid-clear reset rd_data", 32'(rd_data), 32'h0);
        checkOutput("mid-clear reset rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("mid-clear reset busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b1;
        wait_ready(n);
        checkOutput("restarted clear cycles", 32'(n), 32'd256);
        applyStimulus(1'b1, 8'h10, 1'b0, '0, '0, 1'b0);
        idle();
        checkOutput("0x10 after restart", 32'(rd_data), 32'h00);

        // Random traffic in a narrow address window to provoke collisions.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 6), 8'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                          8'($urandom), 1'($urandom_range(0, 199) == 0));
        end
        idle();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
